divu_hilo: RTL and testbench



---
 rtl/divu_hilo_pkg.sv | 24 ++
 rtl/divu_hilo_step.sv | 28 ++
 rtl/divu_hilo.sv | 133 +++++++++++++
 tb/tb_divu_hilo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/divu_hilo_pkg.sv
// rtl/divu_hilo_pkg.sv - shared function codes and divider state encoding
package divu_hilo_pkg;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } divu_state_e;

  function automatic logic is_divu(input logic [5:0] fn);
    return fn == FN_DIVU;
  endfunction

endpackage

// File: rtl/divu_hilo_step.sv
// rtl/divu_hilo_step.sv - one combinational restoring-division step
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    // The extra top bit keeps the shifted remainder exact before the subtract.
    shifted = {rem, q[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divu_hilo.sv
// rtl/divu_hilo.sv - multi-cycle DIVU unit owning the HI (remainder) / LO (quotient) pair
module divu_hilo
  import divu_hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  divu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             accept;
  logic             last_step;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .q        (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_next   (step_quo)
  );

  assign accept    = (state_q == ST_IDLE) && start && is_divu(Signal);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // busy stays up through the cycle in which done is visible.
  always_comb begin
    busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
    done_d = (state_q == ST_DONE);
  end

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    dz_d  = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          quo_d = dataA;
          dvs_d = dataB;
          rem_d = '0;
          cnt_d = '0;
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        hi_d = rem_q;
        lo_d = quo_q;
        dz_d = (dvs_q == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dz_q   <= dz_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign HiOut    = hi_q;
  assign LoOut    = lo_q;

endmodule

// File: tb/tb_divu_hilo.sv
// tb/tb_divu_hilo.sv - self-checking bench for divu_hilo against an arithmetic reference
module tb_divu_hilo;
  import divu_hilo_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic        start;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] HiOut;
  logic [31:0] LoOut;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;

  divu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .dataA    (dataA),
    .dataB    (dataB),
    .Signal   (Signal),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .HiOut    (HiOut),
    .LoOut    (LoOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(1'b0));
    check({tag, "_done"}, 32'(done), 32'(1'b0));
    check({tag, "_hi"}, HiOut, exp_hi);
    check({tag, "_lo"}, LoOut, exp_lo);
    check({tag, "_dz"}, 32'(div_zero), 32'(exp_dz));
  endtask

  // mode 0 plain, 1 ignored strobes mid-run, 2 reset at cycle 15, 3 request on the DONE edge
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int mode,
                        input logic [31:0] na, input logic [31:0] nb);
    int lat;
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;
    start  = 1'b1;
    Signal = FN_DIVU;
    dataA  = a;
    dataB  = b;
    @(negedge clk);
    start = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
    check("busy_after_accept", 32'(busy), 32'(1'b1));
    lat = 0;
    forever begin
      if (done === 1'b1) break;
      if (lat >= 40) begin
        check("done_timeout", 32'(lat), 32'd33);
        break;
      end
      start = 1'b0;
      check("run_busy", 32'(busy), 32'(1'b1));
      check("run_hi_hold", HiOut, exp_hi);
      check("run_lo_hold", LoOut, exp_lo);
      check("run_dz_hold", 32'(div_zero), 32'(exp_dz));
      if (mode == 1 && lat == 10) begin
        start = 1'b1; Signal = FN_DIVU; dataA = 32'd50; dataB = 32'd5;
      end
      if (mode == 1 && lat == 20) begin
        start = 1'b1; Signal = FN_ADD; dataA = 32'd77; dataB = 32'd3;
      end
      if (mode == 2 && lat == 15) begin
        reset = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        check_idle_state("abort");
        @(negedge clk);
        reset = 1'b1;
        Signal = FN_DIVU;
        return;
      end
      if (mode == 3 && lat == 32) begin
        start = 1'b1; Signal = FN_DIVU; dataA = na; dataB = nb;
      end
      @(negedge clk);
      lat++;
    end
    if (b == 0) begin
      ref_hi = a;
      ref_lo = 32'hFFFF_FFFF;
    end else begin
      ref_hi = a % b;
      ref_lo = a / b;
    end
    check("latency", 32'(lat), 32'd33);
    check("done_busy", 32'(busy), 32'(1'b1));
    check("done_hi", HiOut, ref_hi);
    check("done_lo", LoOut, ref_lo);
    check("done_dz", 32'(div_zero), 32'(b == 0));
    exp_hi = ref_hi;
    exp_lo = ref_lo;
    exp_dz = (b == 0);
  endtask

  task automatic finish_check(input string tag);
    start = 1'b0;
    @(negedge clk);
    check_idle_state(tag);
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    Signal = FN_ADD;
    dataA  = '0;
    dataB  = '0;
    repeat (3) @(negedge clk);
    check_idle_state("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_state("after_reset");

    // Non-DIVU codes with start must not launch anything.
    Signal = FN_MFHI; start = 1'b1; dataA = 32'd9; dataB = 32'd2;
    @(negedge clk);
    Signal = FN_SRL;
    @(negedge clk);
    start = 1'b0;
    check_idle_state("non_divu");

    do_div(32'd100, 32'd7, 0, '0, '0);
    check("lo_100_7", LoOut, 32'd14);
    check("hi_100_7", HiOut, 32'd2);
    finish_check("post_100_7");

    do_div(32'hFFFF_FFFF, 32'd1, 0, '0, '0);
    finish_check("post_max_1");
    do_div(32'h8000_0000, 32'h8000_0001, 0, '0, '0);
    check("hi_8000", HiOut, 32'h8000_0000);
    finish_check("post_8000");

    do_div(32'd5, 32'd0, 0, '0, '0);
    check("dz_5_0", 32'(div_zero), 32'd1);
    finish_check("post_div0");
    do_div(32'd9, 32'd3, 0, '0, '0);
    finish_check("post_9_3");

    do_div(32'd100, 32'd7, 1, '0, '0);
    finish_check("post_ignored");

    do_div(32'd1234, 32'd5, 2, '0, '0);
    check_idle_state("after_abort_release");
    do_div(32'd20, 32'd6, 0, '0, '0);
    finish_check("post_20_6");

    do_div(32'd20, 32'd6, 3, 32'd45, 32'd4);
    do_div(32'd45, 32'd4, 0, '0, '0);
    check("lo_45_4", LoOut, 32'd11);
    finish_check("post_b2b");

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      do_div(ra, rb, 0, '0, '0);
      if ($urandom_range(0, 1) == 1) finish_check("post_rand");
    end
    finish_check("final");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
